// File: rtl/id_scoreboard_pkg.sv
// Shared decode-stage constants: register-file geometry and RV32 major opcodes
// used to derive the uses_rs1 / uses_rs2 / writes_rd qualifiers.
package id_scoreboard_pkg;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
endpackage

// File: rtl/id_scoreboard_sb_reg_counter.sv
// Per-register pending-write counter; next value visible one edge after inc/dec.
// No backpressure of its own: release beyond zero clamps and raises underflow.
module sb_reg_counter
  import id_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic [1:0]       dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic [1:0]       dec_applied,
  output logic             underflow
);
  logic [CNT_W:0]   sum;
  logic [CNT_W:0]   diff;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    sum         = {1'b0, cnt} + (CNT_W+1)'(inc);
    diff        = sum - (CNT_W+1)'(dec);
    cnt_nxt     = cnt;
    dec_applied = '0;
    underflow   = 1'b0;
    if (clr) begin
      cnt_nxt = '0;
    end else if ((CNT_W+1)'(dec) > sum) begin
      // only what was actually pending is retired, so the total stays consistent
      cnt_nxt     = '0;
      dec_applied = 2'(sum);
      underflow   = 1'b1;
    end else begin
      dec_applied = dec;
      if (diff > {1'b0, {CNT_W{1'b1}}}) cnt_nxt = '1;
      else                               cnt_nxt = CNT_W'(diff);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else          cnt <= cnt_nxt;
  end
endmodule

// File: rtl/id_scoreboard.sv
// Decode hazard scoreboard: combinational id_ready gates RAW/WAW/capacity; issue and
// release update pending counts one edge later; flush clears all pending state.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 3,
  parameter int INF_W        = 3,
  parameter int WAW_STALL    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 id_writes_rd,
  output logic                 id_ready,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 kill_valid,
  input  logic [REG_IDX_W-1:0] kill_rd,
  input  logic                 flush,
  output logic [NUM_REGS-1:0]  busy_vec,
  output logic [INF_W-1:0]     inflight_cnt,
  output logic [31:0]          stall_cycles,
  output logic                 err_underflow
);
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0][1:0]       dec_applied;
  logic [NUM_REGS-1:0]            underflow;
  logic                           rd_nz, raw, waw, full, issue;
  logic [6:0]                     dec_total;

  // x0 is never tracked
  assign cnt[0]         = '0;
  assign dec_applied[0] = '0;
  assign underflow[0]   = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic       inc;
    logic [1:0] dec;
    assign inc = issue && (id_rd == REG_IDX_W'(r));
    assign dec = 2'(wb_valid && !flush && (wb_rd == REG_IDX_W'(r)))
               + 2'(kill_valid && !flush && (kill_rd == REG_IDX_W'(r)));
    sb_reg_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk         (clk),
      .reset_n     (reset_n),
      .inc         (inc),
      .dec         (dec),
      .clr         (flush),
      .cnt         (cnt[r]),
      .dec_applied (dec_applied[r]),
      .underflow   (underflow[r])
    );
  end

  always_comb begin
    busy_vec  = '0;
    dec_total = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_vec[r] = |cnt[r];
      dec_total   = dec_total + 7'(dec_applied[r]);
    end
  end

  assign rd_nz = id_writes_rd && (id_rd != '0);
  assign raw   = (id_uses_rs1 && (id_rs1 != '0) && (cnt[id_rs1] != '0))
              || (id_uses_rs2 && (id_rs2 != '0) && (cnt[id_rs2] != '0));
  assign waw   = (WAW_STALL != 0) && rd_nz && (cnt[id_rd] != '0);
  assign full  = rd_nz && ((inflight_cnt == INF_W'(MAX_INFLIGHT)) || (cnt[id_rd] == '1));
  assign id_ready = reset_n && !flush && !raw && !waw && !full;
  assign issue    = id_valid && id_ready && rd_nz;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_cnt  <= '0;
      stall_cycles  <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (flush) inflight_cnt <= '0;
      else       inflight_cnt <= INF_W'(8'(inflight_cnt) + 8'(issue) - 8'(dec_total));
      if (|underflow) err_underflow <= 1'b1;
      if (id_valid && !id_ready && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: directed literal checks plus randomized traffic against
// a per-register pending-count model compared on every falling edge.
module tb_id_scoreboard;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_writes_rd;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd, kill_rd;
  logic        wb_valid, kill_valid, flush;
  logic        id_ready, err_underflow;
  logic [31:0] busy_vec, stall_cycles;
  logic [2:0]  inflight_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cnt_m [32];
  int          infl_m;
  logic [31:0] stall_m;
  bit          err_m;

  always #5 clk = ~clk;

  id_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(3), .INF_W(3), .WAW_STALL(1)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_writes_rd(id_writes_rd), .id_ready(id_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .kill_valid(kill_valid), .kill_rd(kill_rd), .flush(flush), .busy_vec(busy_vec),
    .inflight_cnt(inflight_cnt), .stall_cycles(stall_cycles), .err_underflow(err_underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    bit raw, waw, full, rd_nz;
    if (reset_n !== 1'b1 || flush) return 1'b0;
    raw   = (id_uses_rs1 && id_rs1 != 0 && cnt_m[id_rs1] != 0)
         || (id_uses_rs2 && id_rs2 != 0 && cnt_m[id_rs2] != 0);
    rd_nz = id_writes_rd && id_rd != 0;
    waw   = rd_nz && cnt_m[id_rd] != 0;
    full  = rd_nz && (infl_m == 3 || cnt_m[id_rd] == 3);
    return !(raw || waw || full);
  endfunction

  // Reference: pending writes per register, total derived as their sum.
  always @(posedge clk or negedge reset_n) begin
    bit rdy;
    int inc, dec, tot;
    if (!reset_n) begin
      foreach (cnt_m[i]) cnt_m[i] = 0;
      infl_m  = 0;
      stall_m = 0;
      err_m   = 0;
    end else begin
      rdy = model_ready();
      if (id_valid && !rdy && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 1;
      tot = 0;
      for (int r = 1; r < 32; r++) begin
        if (flush) cnt_m[r] = 0;
        else begin
          inc = (id_valid && rdy && id_writes_rd && id_rd == r) ? 1 : 0;
          dec = ((wb_valid && wb_rd == r) ? 1 : 0) + ((kill_valid && kill_rd == r) ? 1 : 0);
          if (dec > cnt_m[r] + inc) begin
            cnt_m[r] = 0;
            err_m    = 1;
          end else cnt_m[r] = cnt_m[r] + inc - dec;
        end
        tot += cnt_m[r];
      end
      infl_m = tot;
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_busy;
    exp_busy = '0;
    for (int i = 0; i < 32; i++) exp_busy[i] = (cnt_m[i] != 0);
    chk("id_ready", 32'(id_ready), 32'(model_ready()));
    chk("busy_vec", busy_vec, exp_busy);
    chk("inflight_cnt", 32'(inflight_cnt), 32'(infl_m));
    chk("stall_cycles", stall_cycles, stall_m);
    chk("err_underflow", 32'(err_underflow), 32'(err_m));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_writes_rd = 0;
    wb_valid = 0; wb_rd = 0; kill_valid = 0; kill_rd = 0; flush = 0;
  endtask

  task automatic op(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                    input logic [4:0] rd, input logic u1, input logic u2, input logic w);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_writes_rd = w;
  endtask

  initial begin
    reset_n = 0;
    idle();
    repeat (2) step();
    @(negedge clk);
    chk("rst_ready", 32'(id_ready), 0);
    chk("rst_busy", busy_vec, 0);
    chk("rst_infl", 32'(inflight_cnt), 0);
    chk("rst_stall", stall_cycles, 0);
    step();
    reset_n = 1;

    // addi x5 issues and marks x5 busy
    op(1, 0, 0, 5, 0, 0, 1);
    @(negedge clk); chk("addi_ready", 32'(id_ready), 1);
    step(); idle();
    @(negedge clk); chk("addi_busy", busy_vec, 32'h0000_0020); chk("addi_infl", 32'(inflight_cnt), 1);
    step();

    // dependent add held three cycles, x5 written back in the third
    op(1, 5, 0, 6, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin wb_valid = 1; wb_rd = 5; end
      @(negedge clk); chk("raw_hold", 32'(id_ready), 0);
      step();
    end
    wb_valid = 0;
    @(negedge clk);
    chk("raw_release", 32'(id_ready), 1);
    chk("raw_busy5", 32'(busy_vec[5]), 0);
    chk("stall_total", stall_cycles, 3);
    step(); idle();
    @(negedge clk); chk("add_busy", busy_vec, 32'h0000_0040);
    step(); wb_valid = 1; wb_rd = 6; step(); wb_valid = 0;
    @(negedge clk); chk("drain_infl", 32'(inflight_cnt), 0);
    step();

    // capacity limit
    for (int r = 1; r <= 3; r++) begin op(1, 0, 0, 5'(r), 0, 0, 1); step(); end
    op(1, 0, 0, 4, 0, 0, 1);
    @(negedge clk); chk("cap_infl", 32'(inflight_cnt), 3); chk("cap_hold", 32'(id_ready), 0);
    step();
    op(1, 10, 11, 0, 1, 1, 0);
    @(negedge clk); chk("nowrite_ready", 32'(id_ready), 1);
    step();

    // flush with a concurrent issue
    op(1, 0, 0, 8, 0, 0, 1); flush = 1;
    @(negedge clk); chk("flush_ready", 32'(id_ready), 0);
    step(); idle();
    @(negedge clk); chk("flush_infl", 32'(inflight_cnt), 0); chk("flush_busy", busy_vec, 0);
    step();

    // same-cycle issue and writeback on x7 nets to zero
    op(1, 0, 0, 7, 0, 0, 1); wb_valid = 1; wb_rd = 7;
    @(negedge clk); chk("net_ready", 32'(id_ready), 1);
    step(); idle();
    @(negedge clk); chk("net_busy", busy_vec, 0); chk("net_infl", 32'(inflight_cnt), 0);
    chk("net_err", 32'(err_underflow), 0);
    step();

    // wb + kill on a single pending write underflows
    op(1, 0, 0, 7, 0, 0, 1); step(); idle();
    wb_valid = 1; wb_rd = 7; kill_valid = 1; kill_rd = 7; step(); idle();
    @(negedge clk); chk("uf_err", 32'(err_underflow), 1); chk("uf_busy", busy_vec, 0);
    chk("uf_infl", 32'(inflight_cnt), 0);
    step();

    // x0 is ignored everywhere
    op(1, 0, 0, 0, 1, 0, 1); wb_valid = 1; wb_rd = 0;
    @(negedge clk); chk("x0_ready", 32'(id_ready), 1);
    step(); idle();
    @(negedge clk); chk("x0_busy", busy_vec, 0); chk("x0_infl", 32'(inflight_cnt), 0);
    step();
    flush = 1; step(); flush = 0;
    @(negedge clk); chk("err_sticky", 32'(err_underflow), 1);
    step();

    // async reset in the middle of a stall
    op(1, 0, 0, 9, 0, 0, 1); step();
    op(1, 9, 0, 12, 1, 0, 1); step(); step();
    #1 reset_n = 0;
    #1;
    chk("arst_ready", 32'(id_ready), 0);
    chk("arst_busy", busy_vec, 0);
    chk("arst_infl", 32'(inflight_cnt), 0);
    chk("arst_stall", stall_cycles, 0);
    chk("arst_err", 32'(err_underflow), 0);
    step(); idle(); reset_n = 1;
    step();

    for (int c = 0; c < 3000; c++) begin
      op(1'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
         5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 9) < 7));
      wb_valid   = ($urandom_range(0, 99) < 35);
      wb_rd      = 5'($urandom_range(0, 7));
      kill_valid = ($urandom_range(0, 99) < 10);
      kill_rd    = 5'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 29) == 0);
      step();
    end
    idle();
    step();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
